prio_encoder_act: RTL and testbench
===================================

Name: prio_encoder_act

Overview:
- Parametrised, registered priority encoder: N_IN one-hot/multi-hot inputs in, binary index out.
- Uses a valid/ready handshake on both sides.
- Built-in switching-activity counters on input and output buses feed the power-estimation datapath, replacing the flat combinational 4x2 encoder.
- Sits between stimulus sources and the activity-accumulation logic.

Parameters:
- N_IN, 8, number of input lines (>=2).
- OUT_W, $clog2(N_IN), encoded index width; derived, do not override.
- CNT_W, 16, width of each activity/sample counter.
- LSB_PRIO, 0, priority mode: 0 = highest set index wins; 1 = lowest set index wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  d is valid this cycle.
- in_ready  out  1  block can accept d this cycle.
- d  in  N_IN  request lines.
- out_valid  out  1  encoded result valid.
- out_ready  in  1  downstream accepts result.
- out  out  OUT_W  encoded index of the winning line.
- out_zero  out  1  accepted d was all zeros.
- out_multi  out  1  accepted d had more than one bit set.
- clr_cnt  in  1  synchronous clear of all counters.
- in_tgl_cnt  out  CNT_W  cumulative input bit toggles.
- out_tgl_cnt  out  CNT_W  cumulative output-index bit toggles.
- sample_cnt  out  CNT_W  number of accepted samples.

Behaviour:
- Reset (async, rst_n=0): out_valid, out, out_zero, out_multi, all three counters, d_prev and out_prev go to 0 immediately. in_ready=1 after reset.
- Accept: accept = in_valid & in_ready, where in_ready = !out_valid | out_ready. Zero-bubble back-to-back throughput is required.
- Latency: 1 cycle. On accept, out/out_zero/out_multi are registered and out_valid=1 on the next edge.
- Holding results: out_valid clears when out_ready=1 and no new accept occurs. While out_valid=1 and out_ready=0, outputs hold stable.
- Encoding when d=0: out=0 and out_zero=1.
- Encoding when d!=0: out = index of highest set bit (LSB_PRIO=0) or lowest set bit (LSB_PRIO=1). out_zero=0.
- out_multi = popcount(d)>1.
- Activity update, only on accept:
  - in_tgl_cnt += popcount(d ^ d_prev).
  - out_tgl_cnt += popcount(out_next ^ out_prev).
  - sample_cnt += 1.
  - Then d_prev<=d and out_prev<=out_next.
- Activity rules:
  - Non-accepted cycles contribute nothing.
  - Repeated identical samples add 0 toggles but still increment sample_cnt.
- Saturation: all counters saturate at 2^CNT_W-1 and never wrap. The add uses a CNT_W+OUT_W+1-bit intermediate, clamped to the maximum.
- clr_cnt=1: counters load 0 at the next edge. d_prev/out_prev are not cleared.
- clr_cnt and accept in the same cycle: counters load that sample's contribution only (clear, then add).
- Reset mid-operation: pending result is discarded with no handshake completion. The next sample's toggles are measured against the zero baseline.
- No FSM beyond the single out_valid state bit. The states are EMPTY and FULL:
  - EMPTY->FULL on accept.
  - FULL->EMPTY on out_ready & !accept.
  - FULL->FULL on accept (refill).

Decomposition:
- Package prio_enc_pkg holds:
  - The clog2 width helper.
  - Priority mode constants PRIO_MSB=0 and PRIO_LSB=1.
  - A saturating-add function parametrised by CNT_W.
- One sub-module, popcount, a parametrised combinational bit counter with output width $clog2(W+1). It is instantiated for the input XOR, the output XOR and the multi-hot detect.

Test Plan:
- Priority modes: N_IN=4, LSB_PRIO=0, d=4'b0110, out_ready=1 -> next cycle out=2'b10, out_multi=1, out_zero=0. With LSB_PRIO=1, same stimulus -> out=2'b01.
- Activity counts: sequence 0001, 0010, 0100, 1000, 0010 (N_IN=4, MSB prio, out_ready=1) -> outs 0,1,2,3,1. Expect:
  - in_tgl_cnt=1+2+2+2+2=9.
  - out_tgl_cnt=0+1+2+1+1=5.
  - sample_cnt=5.
- Zero input: d=4'b0000 accepted -> out=0, out_zero=1. in_tgl_cnt unchanged if d_prev=0; sample_cnt+1.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0. in_valid pulses are not accepted and counters do not change. out_ready=1 then releases one result per cycle with no bubble.
- Saturation and clear: CNT_W=4, alternate 0000/1111 for 6 samples -> in_tgl_cnt=15 (saturated, not wrapped). Then clr_cnt asserted together with an accept of 0000 (after 1111) -> in_tgl_cnt=4, sample_cnt=1.
- Async reset: drop rst_n mid-cycle while out_valid=1 -> out_valid, out and all counters read 0 before the next clock edge. The first post-reset sample d=0001 gives in_tgl_cnt=1.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types, constants and helpers for the activity-counting priority encoder.
package prio_enc_pkg;

   // Priority mode selectors for the LSB_PRIO parameter.
   localparam int PRIO_MSB = 0;
   localparam int PRIO_LSB = 1;

   // Result-slot occupancy: the only state the block keeps beyond its datapath.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_e;

   // Ceiling log2, usable in parameter expressions; returns 0 for v <= 1.
   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r++;
      end
      return r;
   endfunction

   // Saturating add for a counter of cnt_w bits (cnt_w <= 63). The 64-bit
   // intermediate always holds the true sum of a full counter and any
   // increment, so the clamp sees the real overflow and never a wrapped value.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned cnt_w);
      logic [63:0] max_v;
      logic [63:0] sum;
      max_v = (64'd1 << cnt_w) - 64'd1;
      sum   = a + b;
      return (sum > max_v) ? max_v : sum;
   endfunction

endpackage

// File: rtl/popcount.sv
// popcount: combinational count of the set bits in a W-bit vector.
module popcount
   import prio_enc_pkg::*;
#(
   parameter  int W  = 8,
   localparam int CW = clog2(W + 1)
) (
   input  logic [W-1:0]  i_bits,
   output logic [CW-1:0] o_count
);

   // Accumulate the bits one by one; synthesis folds this into an adder tree.
   always_comb begin
      // NOTE: every combinational output gets a default before any conditional
      // logic, so no path leaves it unassigned and a latch cannot be inferred.
      o_count = '0;
      for (int i = 0; i < W; i++) begin
         o_count = o_count + CW'(i_bits[i]);
      end
   end

endmodule

// File: rtl/prio_encoder_act.sv
// prio_encoder_act: registered priority encoder with valid/ready on both sides
// and saturating switching-activity counters on the input and index buses.
module prio_encoder_act
   import prio_enc_pkg::*;
#(
   parameter  int N_IN     = 8,
   parameter  int CNT_W    = 16,
   parameter  int LSB_PRIO = PRIO_MSB,
   localparam int OUT_W    = clog2(N_IN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_zero,
   output logic             out_multi,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] in_tgl_cnt,
   output logic [CNT_W-1:0] out_tgl_cnt,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam int IN_PC_W  = clog2(N_IN + 1);
   localparam int OUT_PC_W = clog2(OUT_W + 1);

   slot_state_e         r_state;
   slot_state_e         w_state_next;
   logic                w_accept;
   logic [OUT_W-1:0]    w_idx;
   logic                w_zero;
   logic                w_multi;
   logic [IN_PC_W-1:0]  w_d_pc;
   logic [IN_PC_W-1:0]  w_in_tgl;
   logic [OUT_PC_W-1:0] w_out_tgl;
   logic [N_IN-1:0]     r_d_prev;
   logic [OUT_W-1:0]    r_out_prev;
   logic [OUT_W-1:0]    r_out;
   logic                r_out_zero;
   logic                r_out_multi;
   logic [CNT_W-1:0]    r_in_tgl_cnt;
   logic [CNT_W-1:0]    r_out_tgl_cnt;
   logic [CNT_W-1:0]    r_sample_cnt;
   logic [CNT_W-1:0]    w_in_base;
   logic [CNT_W-1:0]    w_out_base;
   logic [CNT_W-1:0]    w_samp_base;

   // A full slot frees up in the same cycle it is drained: zero-bubble refill.
   assign in_ready = (r_state == ST_EMPTY) || out_ready;
   assign w_accept = in_valid && in_ready;

   // Pick the winning line; the scan order lets the preferred end overwrite.
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (LSB_PRIO == PRIO_LSB) begin
            if (d[N_IN-1-i]) w_idx = OUT_W'(N_IN - 1 - i);
         end else begin
            if (d[i]) w_idx = OUT_W'(i);
         end
      end
   end

   assign w_zero  = ~|d;
   assign w_multi = (w_d_pc > IN_PC_W'(1));

   popcount #(.W(N_IN)) u_pc_multi (
      .i_bits  (d),
      .o_count (w_d_pc)
   );

   popcount #(.W(N_IN)) u_pc_in_tgl (
      .i_bits  (d ^ r_d_prev),
      .o_count (w_in_tgl)
   );

   popcount #(.W(OUT_W)) u_pc_out_tgl (
      .i_bits  (w_idx ^ r_out_prev),
      .o_count (w_out_tgl)
   );

   // Slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_next;
   end

   // Next slot state: fill on accept, drain when taken without a refill.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
         ST_FULL:  if (!w_accept && out_ready) w_state_next = ST_EMPTY;
         default:  w_state_next = ST_EMPTY;
      endcase
   end

   // Output decode of the slot state.
   always_comb begin
      out_valid = (r_state == ST_FULL);
   end

   // Capture the encoded result and the toggle baselines on every accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_zero  <= 1'b0;
         r_out_multi <= 1'b0;
         r_d_prev    <= '0;
         r_out_prev  <= '0;
      end else if (w_accept) begin
         r_out       <= w_idx;
         r_out_zero  <= w_zero;
         r_out_multi <= w_multi;
         r_d_prev    <= d;
         r_out_prev  <= w_idx;
      end
   end

   // A clear drops the old count so a same-cycle sample adds to zero.
   assign w_in_base   = clr_cnt ? '0 : r_in_tgl_cnt;
   assign w_out_base  = clr_cnt ? '0 : r_out_tgl_cnt;
   assign w_samp_base = clr_cnt ? '0 : r_sample_cnt;

   // Activity counters: saturating accumulate on accept, otherwise hold/clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_tgl_cnt  <= '0;
         r_out_tgl_cnt <= '0;
         r_sample_cnt  <= '0;
      end else if (w_accept) begin
         r_in_tgl_cnt  <= CNT_W'(sat_add(64'(w_in_base), 64'(w_in_tgl), CNT_W));
         r_out_tgl_cnt <= CNT_W'(sat_add(64'(w_out_base), 64'(w_out_tgl), CNT_W));
         r_sample_cnt  <= CNT_W'(sat_add(64'(w_samp_base), 64'd1, CNT_W));
      end else begin
         r_in_tgl_cnt  <= w_in_base;
         r_out_tgl_cnt <= w_out_base;
         r_sample_cnt  <= w_samp_base;
      end
   end

   assign out         = r_out;
   assign out_zero    = r_out_zero;
   assign out_multi   = r_out_multi;
   assign in_tgl_cnt  = r_in_tgl_cnt;
   assign out_tgl_cnt = r_out_tgl_cnt;
   assign sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_prio_encoder_act.sv
// Bench for prio_encoder_act: three instances (N_IN=4) share stimulus --
// MSB priority, LSB priority, and MSB priority with 4-bit counters.
module tb_prio_encoder_act;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [3:0] d = 4'd0;

   logic        msb_in_ready, msb_out_valid, msb_out_zero, msb_out_multi;
   logic [1:0]  msb_out;
   logic [15:0] msb_in_tgl, msb_out_tgl, msb_sample;
   logic        lsb_in_ready, lsb_out_valid, lsb_out_zero, lsb_out_multi;
   logic [1:0]  lsb_out;
   logic [15:0] lsb_in_tgl, lsb_out_tgl, lsb_sample;
   logic        sat_in_ready, sat_out_valid, sat_out_zero, sat_out_multi;
   logic [1:0]  sat_out;
   logic [3:0]  sat_in_tgl, sat_out_tgl, sat_sample;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prio_encoder_act #(.N_IN(4), .CNT_W(16), .LSB_PRIO(0)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(msb_in_ready),
      .d(d), .out_valid(msb_out_valid), .out_ready(out_ready), .out(msb_out),
      .out_zero(msb_out_zero), .out_multi(msb_out_multi), .clr_cnt(clr_cnt),
      .in_tgl_cnt(msb_in_tgl), .out_tgl_cnt(msb_out_tgl), .sample_cnt(msb_sample));

   prio_encoder_act #(.N_IN(4), .CNT_W(16), .LSB_PRIO(1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lsb_in_ready),
      .d(d), .out_valid(lsb_out_valid), .out_ready(out_ready), .out(lsb_out),
      .out_zero(lsb_out_zero), .out_multi(lsb_out_multi), .clr_cnt(clr_cnt),
      .in_tgl_cnt(lsb_in_tgl), .out_tgl_cnt(lsb_out_tgl), .sample_cnt(lsb_sample));

   prio_encoder_act #(.N_IN(4), .CNT_W(4), .LSB_PRIO(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
      .d(d), .out_valid(sat_out_valid), .out_ready(out_ready), .out(sat_out),
      .out_zero(sat_out_zero), .out_multi(sat_out_multi), .clr_cnt(clr_cnt),
      .in_tgl_cnt(sat_in_tgl), .out_tgl_cnt(sat_out_tgl), .sample_cnt(sat_sample));

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int out;
      bit zero;
      bit multi;
      int oprev;
      int in_c;
      int out_c;
      int samp;
   } mstate_t;

   mstate_t    m[3];
   bit         m_valid;
   bit         m_acc;
   logic [3:0] m_dprev;
   int         m_o;

   // Winning index from arithmetic: floor(log2) of the value or of its lowest set bit.
   function automatic int enc(input logic [3:0] v, input bit lsb_mode);
      int x;
      x = int'(v);
      if (x == 0) return 0;
      if (lsb_mode) return $clog2(x & -x);
      return $clog2(x + 1) - 1;
   endfunction

   function automatic int sat(input int v, input int k);
      int mx;
      mx = (k == 2) ? 15 : 65535;
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_dprev = 4'd0;
         for (int k = 0; k < 3; k++) m[k] = '{default: 0};
      end else begin
         m_acc = in_valid && (!m_valid || out_ready);
         for (int k = 0; k < 3; k++) begin
            if (clr_cnt) begin
               m[k].in_c  = 0;
               m[k].out_c = 0;
               m[k].samp  = 0;
            end
            if (m_acc) begin
               m_o = enc(d, k == 1);
               m[k].in_c  = sat(m[k].in_c + $countones(d ^ m_dprev), k);
               m[k].out_c = sat(m[k].out_c + $countones(m_o ^ m[k].oprev), k);
               m[k].samp  = sat(m[k].samp + 1, k);
               m[k].out   = m_o;
               m[k].zero  = (d == 4'd0);
               m[k].multi = ($countones(d) > 1);
               m[k].oprev = m_o;
            end
         end
         if (m_acc) begin
            m_dprev = d;
            m_valid = 1'b1;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic cmp_dut(input int k, input logic ov, input logic ir,
                          input logic [1:0] o, input logic z, input logic mu,
                          input logic [15:0] ic, input logic [15:0] oc,
                          input logic [15:0] sc);
      check($sformatf("out_valid[%0d]", k), int'(ov), int'(m_valid));
      check($sformatf("in_ready[%0d]", k), int'(ir), int'(!m_valid || out_ready));
      if (m_valid) begin
         check($sformatf("out[%0d]", k), int'(o), m[k].out);
         check($sformatf("out_zero[%0d]", k), int'(z), int'(m[k].zero));
         check($sformatf("out_multi[%0d]", k), int'(mu), int'(m[k].multi));
      end
      check($sformatf("in_tgl[%0d]", k), int'(ic), m[k].in_c);
      check($sformatf("out_tgl[%0d]", k), int'(oc), m[k].out_c);
      check($sformatf("sample[%0d]", k), int'(sc), m[k].samp);
   endtask

   // Every cycle, away from the active edge, compare all instances to the model.
   always @(negedge clk) begin
      cmp_dut(0, msb_out_valid, msb_in_ready, msb_out, msb_out_zero, msb_out_multi,
              msb_in_tgl, msb_out_tgl, msb_sample);
      cmp_dut(1, lsb_out_valid, lsb_in_ready, lsb_out, lsb_out_zero, lsb_out_multi,
              lsb_in_tgl, lsb_out_tgl, lsb_sample);
      cmp_dut(2, sat_out_valid, sat_in_ready, sat_out, sat_out_zero, sat_out_multi,
              16'(sat_in_tgl), 16'(sat_out_tgl), 16'(sat_sample));
   end

   // ---------------- directed stimulus helpers ----------------
   // All helpers start and end 1 time unit after a rising edge.
   task automatic send(input logic [3:0] dv, input logic clr, input logic rdy);
      in_valid  = 1'b1;
      d         = dv;
      clr_cnt   = clr;
      out_ready = rdy;
      @(posedge clk); #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   logic [3:0] sat_seq[6];

   initial begin
      sat_seq = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(msb_out_valid), 0);
      check("rst_in_ready", int'(msb_in_ready), 1);
      check("rst_sample", int'(msb_sample), 0);
      rst_n = 1'b1;

      // Priority modes: 0110 -> MSB 2, LSB 1, multi-hot.
      send(4'b0110, 1'b0, 1'b1);
      check("prio_msb_out", int'(msb_out), 2);
      check("prio_lsb_out", int'(lsb_out), 1);
      check("prio_multi", int'(msb_out_multi), 1);
      check("prio_zero", int'(msb_out_zero), 0);
      check("prio_valid", int'(msb_out_valid), 1);

      // Activity counts from a zero baseline.
      do_reset();
      send(4'b0001, 1'b0, 1'b1);
      send(4'b0010, 1'b0, 1'b1);
      send(4'b0100, 1'b0, 1'b1);
      send(4'b1000, 1'b0, 1'b1);
      send(4'b0010, 1'b0, 1'b1);
      check("act_in_tgl", int'(msb_in_tgl), 9);
      check("act_out_tgl", int'(msb_out_tgl), 5);
      check("act_sample", int'(msb_sample), 5);
      check("act_model_in_tgl", m[0].in_c, 9);
      check("act_out", int'(msb_out), 1);

      // Zero input.
      do_reset();
      send(4'b0000, 1'b0, 1'b1);
      check("zero_out", int'(msb_out), 0);
      check("zero_flag", int'(msb_out_zero), 1);
      check("zero_in_tgl", int'(msb_in_tgl), 0);
      check("zero_sample", int'(msb_sample), 1);

      // Backpressure: full slot with out_ready=0 refuses input.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d         = 4'b1000;
      repeat (3) begin
         @(posedge clk); #1;
         check("bp_in_ready", int'(msb_in_ready), 0);
         check("bp_sample", int'(msb_sample), 1);
         check("bp_hold_zero", int'(msb_out_zero), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_rel1_out", int'(msb_out), 3);
      check("bp_rel1_sample", int'(msb_sample), 2);
      d = 4'b0001;
      @(posedge clk); #1;
      check("bp_rel2_out", int'(msb_out), 0);
      check("bp_rel2_valid", int'(msb_out_valid), 1);
      check("bp_rel2_in_tgl", int'(msb_in_tgl), 3);
      check("bp_rel2_out_tgl", int'(msb_out_tgl), 4);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_drain_valid", int'(msb_out_valid), 0);

      // Saturation on 4-bit counters, then clear together with an accept.
      do_reset();
      foreach (sat_seq[i]) send(sat_seq[i], 1'b0, 1'b1);
      check("sat_in_tgl", int'(sat_in_tgl), 15);
      check("sat_sample", int'(sat_sample), 6);
      check("sat_out_tgl", int'(sat_out_tgl), 10);
      check("wide_in_tgl", int'(msb_in_tgl), 20);
      send(4'b0000, 1'b1, 1'b1);
      check("clr_in_tgl", int'(sat_in_tgl), 4);
      check("clr_sample", int'(sat_sample), 1);
      check("clr_out_tgl", int'(sat_out_tgl), 2);

      // Async reset mid-cycle while a result is pending.
      send(4'b1111, 1'b0, 1'b1);
      out_ready = 1'b0;
      check("ar_pre_valid", int'(msb_out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", int'(msb_out_valid), 0);
      check("ar_out", int'(msb_out), 0);
      check("ar_in_tgl", int'(msb_in_tgl), 0);
      check("ar_sample", int'(sat_sample), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(4'b0001, 1'b0, 1'b1);
      check("ar_post_in_tgl", int'(msb_in_tgl), 1);

      // Randomised traffic with occasional clears and mid-cycle resets.
      repeat (600) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         d         = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_cnt   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
